// File: rtl/bw_mul_pkg.sv
// Shared definitions for the sequential Baugh-Wooley multiplier.
//   state_t       : FSM encoding (IDLE, RUN, DONE), also exported on the debug port.
//   bw_correction : constant added with the last row in signed mode,
//                   (1 << width) + (1 << (2*width-1)), returned in 64 bits.
package bw_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // width is at least 2, so the two set bits never coincide and OR equals ADD.
  function automatic logic [63:0] bw_correction(input int width);
    return (64'd1 << width) | (64'd1 << (2 * width - 1));
  endfunction

endpackage

// File: rtl/bw_mul_seq_pp_row.sv
// One Baugh-Wooley partial-product row (purely combinational).
//   i_a         : latched multiplicand
//   i_b_bit     : multiplier bit b[i] for this row
//   i_row       : row index i
//   i_is_signed : 1 = apply the Baugh-Wooley inversions
//   o_row       : WIDTH-bit row, bit j = a[j] & b[i] (inverted where required)
module bw_pp_row #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_b_bit,
  input  logic [CNT_W-1:0] i_row,
  input  logic             i_is_signed,
  output logic [WIDTH-1:0] o_row
);

  logic w_last_row;
  assign w_last_row = (i_row == CNT_W'(WIDTH - 1));

  // A term is inverted when exactly one of (j is the top column, i is the
  // top row) holds; the corner term a[W-1]&b[W-1] keeps its true polarity.
  always_comb begin
    o_row = '0;
    for (int j = 0; j < WIDTH; j++) begin
      o_row[j] = i_a[j] & i_b_bit;
      if (i_is_signed && ((j == WIDTH - 1) != w_last_row)) begin
        o_row[j] = ~(i_a[j] & i_b_bit);
      end
    end
  end

endmodule

// File: rtl/bw_mul_seq.sv
// Iterative WIDTH x WIDTH Baugh-Wooley multiplier, one partial-product row
// per clock, signed or unsigned per operand pair.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (a, b, is_signed)
//   out_valid / out_ready : result handshake (p)
//   dbg_state             : current FSM state, for observation only
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is high only in IDLE and out_valid only in DONE, so
// at most one operation is in flight; in_valid outside IDLE is ignored.
module bw_mul_seq
  import bw_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output state_t             dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [63:0]      CORR_FULL = bw_correction(WIDTH);
  localparam logic [PW-1:0]    CORR      = CORR_FULL[PW-1:0];
  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_p;

  logic             w_last;
  logic [WIDTH-1:0] w_b_shift;
  logic [WIDTH-1:0] w_row;
  logic [PW-1:0]    w_row_sh;
  logic [PW-1:0]    w_corr_add;
  logic [PW-1:0]    w_acc_next;

  assign w_last    = (r_state == RUN) && (r_cnt == LAST_ROW);
  // Select b[i] by shifting, which keeps the counter wider than a bit index.
  assign w_b_shift = r_b >> r_cnt;

  bw_pp_row #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_row (
    .i_a         (r_a),
    .i_b_bit     (w_b_shift[0]),
    .i_row       (r_cnt),
    .i_is_signed (r_signed),
    .o_row       (w_row)
  );

  // Sum is modulo 2^PW: carries past the top bit fall off naturally.
  assign w_row_sh   = {{WIDTH{1'b0}}, w_row} << r_cnt;
  assign w_corr_add = (w_last && r_signed) ? CORR : '0;
  assign w_acc_next = r_acc + w_row_sh + w_corr_add;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = RUN;
      end
      RUN: begin
        if (r_cnt == LAST_ROW) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_p      <= '0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_a      <= a;
        r_b      <= b;
        r_signed <= is_signed;
        r_cnt    <= '0;
        r_acc    <= '0;
      end
      if (r_state == RUN) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
        // Result gets its own register so it stays put after the handshake
        // while the accumulator is recycled by the next operation.
        if (w_last) r_p <= w_acc_next;
      end
    end
  end

  assign p         = r_p;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bw_mul_seq.sv
// Directed and random checks of bw_mul_seq at WIDTH=4 and WIDTH=8 against an
// arithmetic product model.
module tb_bw_mul_seq;
  import bw_mul_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] a_drv, b_drv;
  logic s_drv, out_ready;
  logic in_valid4, in_valid8;
  logic ir4, ir8, ov4, ov8;
  logic [7:0]  p4;
  logic [15:0] p8;
  state_t st4, st8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bw_mul_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(ir4),
    .a(a_drv[3:0]), .b(b_drv[3:0]), .is_signed(s_drv),
    .out_valid(ov4), .out_ready(out_ready), .p(p4), .dbg_state(st4)
  );

  bw_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(ir8),
    .a(a_drv), .b(b_drv), .is_signed(s_drv),
    .out_valid(ov8), .out_ready(out_ready), .p(p8), .dbg_state(st8)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact product: operands read as integers (two's complement when s=1).
  function automatic logic [63:0] ref_prod(input int w, input logic [7:0] x,
                                           input logic [7:0] y, input bit s);
    longint vx, vy, pr;
    logic [63:0] ux, uy, mask;
    mask = (64'd1 << w) - 64'd1;
    ux = {56'b0, x} & mask;
    uy = {56'b0, y} & mask;
    vx = longint'(ux);
    vy = longint'(uy);
    if (s && ux[w-1]) vx = vx - (longint'(1) << w);
    if (s && uy[w-1]) vy = vy - (longint'(1) << w);
    pr = vx * vy;
    return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic get_ov(input int w);
    return (w == 4) ? ov4 : ov8;
  endfunction
  function automatic logic get_ir(input int w);
    return (w == 4) ? ir4 : ir8;
  endfunction
  function automatic logic [63:0] get_p(input int w);
    return (w == 4) ? {56'b0, p4} : {48'b0, p8};
  endfunction

  // One operation on the selected unit, which must be idle on entry.
  // Operand inputs are scrambled while it runs; only latched values may matter.
  task automatic do_op(input int w, input logic [7:0] x, input logic [7:0] y,
                       input bit s, input logic [63:0] exp, input string tag);
    int lat;
    @(posedge clk); #1;
    a_drv = x; b_drv = y; s_drv = s;
    if (w == 4) in_valid4 = 1'b1; else in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; in_valid8 = 1'b0;
    check({tag, " busy_in_ready"}, {63'b0, get_ir(w)}, 64'd0);
    lat = 0;
    while (!get_ov(w) && lat < 40) begin
      a_drv = 8'($urandom); b_drv = 8'($urandom); s_drv = ~s;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(w));
    check({tag, " p"}, get_p(w), exp);
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, " ov_drop"}, {63'b0, get_ov(w)}, 64'd0);
      check({tag, " back_idle"}, {63'b0, get_ir(w)}, 64'd1);
    end
  endtask

  initial begin
    logic [63:0] held;
    logic [7:0] x, y;
    bit s;
    rst = 1'b1; a_drv = '0; b_drv = '0; s_drv = 1'b0;
    in_valid4 = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1;
    #12;
    check("rst in_ready", {63'b0, ir4}, 64'd1);
    check("rst out_valid", {63'b0, ov4}, 64'd0);
    check("rst p", {56'b0, p4}, 64'd0);
    check("rst state", {62'b0, st4}, {62'b0, IDLE});
    check("rst p8", {48'b0, p8}, 64'd0);
    @(negedge clk); rst = 1'b0;

    do_op(4, 8'h09, 8'h03, 1'b1, 64'hEB, "s -7*3");
    do_op(4, 8'h09, 8'h03, 1'b0, 64'h1B, "u 9*3");
    do_op(4, 8'h08, 8'h08, 1'b1, 64'h40, "s -8*-8");
    do_op(4, 8'h0F, 8'h0F, 1'b0, 64'hE1, "u 15*15");
    do_op(4, 8'h00, 8'h0F, 1'b1, 64'h00, "s 0*-1");
    do_op(4, 8'h0F, 8'h0F, 1'b1, 64'h01, "s -1*-1");
    do_op(4, 8'h00, 8'h00, 1'b0, 64'h00, "u 0*0");

    // Backpressure: result held, busy, new operands ignored.
    out_ready = 1'b0;
    do_op(4, 8'h07, 8'h05, 1'b0, 64'h23, "bp op");
    held = 64'h23;
    for (int k = 0; k < 10; k++) begin
      a_drv = 8'($urandom); b_drv = 8'($urandom); s_drv = 1'($urandom);
      in_valid4 = 1'(k % 2);
      @(posedge clk); #1;
      check("bp p_stable", {56'b0, p4}, held);
      check("bp in_ready", {63'b0, ir4}, 64'd0);
      check("bp out_valid", {63'b0, ov4}, 64'd1);
    end
    in_valid4 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release ov", {63'b0, ov4}, 64'd0);
    check("bp release idle", {62'b0, st4}, {62'b0, IDLE});
    check("bp p_kept", {56'b0, p4}, held);
    do_op(4, 8'h06, 8'h0D, 1'b1, 64'hEE, "after bp");

    // Reset two cycles after acceptance.
    @(posedge clk); #1;
    a_drv = 8'h05; b_drv = 8'h06; s_drv = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun rst ov", {63'b0, ov4}, 64'd0);
    check("midrun rst p", {56'b0, p4}, 64'd0);
    check("midrun rst ir", {63'b0, ir4}, 64'd1);
    @(negedge clk); rst = 1'b0;
    do_op(4, 8'h0B, 8'h03, 1'b0, 64'h21, "after rst");

    do_op(8, 8'h80, 8'h80, 1'b1, 64'h4000, "w8 s min*min");
    do_op(8, 8'h00, 8'h00, 1'b1, 64'h0000, "w8 s 0*0");

    for (int k = 0; k < 500; k++) begin
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom_range(0, 1));
      do_op(8, x, y, s, ref_prod(8, x, y, s), "w8 rand");
    end
    for (int k = 0; k < 100; k++) begin
      x = 8'($urandom_range(0, 15)); y = 8'($urandom_range(0, 15));
      s = 1'($urandom_range(0, 1));
      do_op(4, x, y, s, ref_prod(4, x, y, s), "w4 rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
